// File: rtl/exe_stage_if.sv
// Decode -> execute -> memory handshake, hazard/forward feedback and data SRAM request.
// slave is the execute stage's view; master is the surrounding pipeline's view.
interface exe_stage_if;
  logic         ms_allowin;
  logic         es_allowin;
  logic         ds_to_es_valid;
  logic [149:0] ds_to_es_bus;
  logic         es_to_ms_valid;
  logic [70:0]  es_to_ms_bus;
  logic [7:0]   es_hazard_bus;
  logic [31:0]  es_forward;
  logic         data_sram_en;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

  modport slave (
    input  ms_allowin, ds_to_es_valid, ds_to_es_bus,
    output es_allowin, es_to_ms_valid, es_to_ms_bus, es_hazard_bus, es_forward,
           data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
  );

  modport master (
    output ms_allowin, ds_to_es_valid, ds_to_es_bus,
    input  es_allowin, es_to_ms_valid, es_to_ms_bus, es_hazard_bus, es_forward,
           data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
  );
endinterface

// File: rtl/exe_stage.sv
// Single-cycle execute stage: one register slot, ALU result and SRAM request one cycle after capture.
// Backpressure: while ms_allowin=0 the slot holds, es_allowin drops and no SRAM access is issued.
module exe_stage (
  input logic        clk,
  input logic        resetn,
  exe_stage_if.slave io
);

  typedef struct packed {
    logic [11:0] alu_op;
    logic        load_op;
    logic        src1_is_pc;
    logic        src2_is_imm;
    logic        gr_we;
    logic        mem_we;
    logic [4:0]  dest;
    logic [31:0] imm;
    logic [31:0] rj_value;
    logic [31:0] rkd_value;
    logic [31:0] pc;
  } ds_bus_t;

  logic        es_valid;
  ds_bus_t     es_bus;
  logic        es_ready_go;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [4:0]  sa;
  logic [31:0] alu_result;
  logic        sram_en;

  assign es_ready_go   = 1'b1;
  assign io.es_allowin = !es_valid || (es_ready_go && io.ms_allowin);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      es_valid <= 1'b0;
    end else if (io.es_allowin) begin
      es_valid <= io.ds_to_es_valid;
    end
  end

  // Payload is left unreset; it is meaningless whenever es_valid is low.
  always_ff @(posedge clk) begin
    if (resetn && io.ds_to_es_valid && io.es_allowin) begin
      es_bus <= ds_bus_t'(io.ds_to_es_bus);
    end
  end

  assign src1 = es_bus.src1_is_pc  ? es_bus.pc  : es_bus.rj_value;
  assign src2 = es_bus.src2_is_imm ? es_bus.imm : es_bus.rkd_value;
  assign sa   = src2[4:0];

  // One-hot op select: AND-OR mux so an all-zero alu_op gives zero.
  assign alu_result =
      ({32{es_bus.alu_op[0]}}  & (src1 + src2))
    | ({32{es_bus.alu_op[1]}}  & (src1 - src2))
    | ({32{es_bus.alu_op[2]}}  & {31'b0, $signed(src1) < $signed(src2)})
    | ({32{es_bus.alu_op[3]}}  & {31'b0, src1 < src2})
    | ({32{es_bus.alu_op[4]}}  & (src1 & src2))
    | ({32{es_bus.alu_op[5]}}  & ~(src1 | src2))
    | ({32{es_bus.alu_op[6]}}  & (src1 | src2))
    | ({32{es_bus.alu_op[7]}}  & (src1 ^ src2))
    | ({32{es_bus.alu_op[8]}}  & (src1 << sa))
    | ({32{es_bus.alu_op[9]}}  & (src1 >> sa))
    | ({32{es_bus.alu_op[10]}} & 32'($signed(src1) >>> sa))
    | ({32{es_bus.alu_op[11]}} & src2);

  assign io.es_to_ms_valid = es_valid && es_ready_go;
  assign io.es_to_ms_bus   = {es_bus.load_op, es_bus.gr_we, es_bus.dest, alu_result, es_bus.pc};
  assign io.es_hazard_bus  = {es_bus.load_op, es_valid, es_bus.gr_we, es_bus.dest};
  assign io.es_forward     = alu_result;

  // Issue only in the cycle the instruction leaves, so a stall never repeats the access.
  assign sram_en            = es_valid && (es_bus.load_op || es_bus.mem_we) && io.ms_allowin;
  assign io.data_sram_en    = sram_en;
  assign io.data_sram_we    = (sram_en && es_bus.mem_we) ? 4'hf : 4'h0;
  assign io.data_sram_addr  = alu_result;
  assign io.data_sram_wdata = es_bus.rkd_value;

endmodule

// File: tb/tb_exe_stage.sv
// Table-driven ALU vectors plus hand sequences for store, load stall and reset; outputs checked by scoreboard.
module tb_exe_stage;

  localparam logic [11:0] OP_ADD = 12'h001, OP_SUB = 12'h002, OP_SLT = 12'h004, OP_SLTU = 12'h008,
                          OP_AND = 12'h010, OP_NOR = 12'h020, OP_OR  = 12'h040, OP_XOR  = 12'h080,
                          OP_SLL = 12'h100, OP_SRL = 12'h200, OP_SRA = 12'h400, OP_LUI  = 12'h800;
  localparam int NV = 16;

  typedef struct {
    logic [11:0] op;
    logic        s1pc;
    logic        s2imm;
    logic [4:0]  dest;
    logic [31:0] rj;
    logic [31:0] rkd;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] exp;
  } vec_t;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;
  vec_t tbl [NV];
  logic [70:0] exp_q [$];
  logic [70:0] exp_bus;

  exe_stage_if u_if ();

  exe_stage dut (
    .clk    (clk),
    .resetn (resetn),
    .io     (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [11:0] op, input logic ld, input logic s1pc, input logic s2imm,
                       input logic grwe, input logic mwe, input logic [4:0] dest,
                       input logic [31:0] imm, input logic [31:0] rj, input logic [31:0] rkd,
                       input logic [31:0] pc);
    u_if.ds_to_es_valid = 1'b1;
    u_if.ds_to_es_bus   = {op, ld, s1pc, s2imm, grwe, mwe, dest, imm, rj, rkd, pc};
  endtask

  task automatic setv(input int i, input logic [11:0] op, input logic s1pc, input logic s2imm,
                      input logic [4:0] dest, input logic [31:0] rj, input logic [31:0] rkd,
                      input logic [31:0] imm, input logic [31:0] pc, input logic [31:0] exp);
    tbl[i].op = op; tbl[i].s1pc = s1pc; tbl[i].s2imm = s2imm; tbl[i].dest = dest;
    tbl[i].rj = rj; tbl[i].rkd = rkd; tbl[i].imm = imm; tbl[i].pc = pc; tbl[i].exp = exp;
  endtask

  // Every transfer to the memory stage must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (u_if.es_to_ms_valid && u_if.ms_allowin) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra act=%h exp=none", u_if.es_to_ms_bus);
      end else begin
        exp_bus = exp_q.pop_front();
        chk("sb_bus", {57'b0, u_if.es_to_ms_bus}, {57'b0, exp_bus});
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;

    setv(0,  OP_ADD,  0, 0, 5'd2,  32'h7fffffff, 32'h1,        32'h0,        32'h1c000100, 32'h80000000);
    setv(1,  OP_SUB,  0, 0, 5'd3,  32'h5,        32'h7,        32'h0,        32'h1c000104, 32'hfffffffe);
    setv(2,  OP_SLT,  0, 0, 5'd4,  32'hffffffff, 32'h1,        32'h0,        32'h1c000108, 32'h1);
    setv(3,  OP_SLTU, 0, 0, 5'd5,  32'hffffffff, 32'h1,        32'h0,        32'h1c00010c, 32'h0);
    setv(4,  OP_AND,  0, 0, 5'd6,  32'hf0f0f0f0, 32'hff00ff00, 32'h0,        32'h1c000110, 32'hf000f000);
    setv(5,  OP_NOR,  0, 0, 5'd7,  32'h0f0f0000, 32'h000000ff, 32'h0,        32'h1c000114, 32'hf0f0ff00);
    setv(6,  OP_OR,   0, 0, 5'd8,  32'h12340000, 32'h00005678, 32'h0,        32'h1c000118, 32'h12345678);
    setv(7,  OP_XOR,  0, 0, 5'd9,  32'hffff0000, 32'h0ff00ff0, 32'h0,        32'h1c00011c, 32'hf00f0ff0);
    setv(8,  OP_SLL,  0, 0, 5'd10, 32'h1,        32'h23,       32'h0,        32'h1c000120, 32'h8);
    setv(9,  OP_SRL,  0, 0, 5'd11, 32'h80000000, 32'h4,        32'h0,        32'h1c000124, 32'h08000000);
    setv(10, OP_SRA,  0, 1, 5'd12, 32'h80000000, 32'h0,        32'h4,        32'h1c000128, 32'hf8000000);
    setv(11, OP_LUI,  0, 1, 5'd13, 32'h0,        32'h0,        32'h12345000, 32'h1c00012c, 32'h12345000);
    setv(12, OP_ADD,  1, 1, 5'd1,  32'h0,        32'h0,        32'h4,        32'h1c000000, 32'h1c000004);
    setv(13, 12'h000, 0, 0, 5'd14, 32'h5,        32'h6,        32'h0,        32'h1c000134, 32'h0);
    setv(14, OP_ADD,  0, 0, 5'd15, 32'hffffffff, 32'h2,        32'h0,        32'h1c000138, 32'h1);
    setv(15, OP_SLL,  0, 0, 5'd16, 32'h1,        32'h1f,       32'h0,        32'h1c00013c, 32'h80000000);

    // Reset with decode presenting an instruction: it must be dropped.
    resetn = 1'b0;
    u_if.ms_allowin = 1'b0;
    drive(OP_ADD, 1'b1, 0, 0, 1, 1, 5'd9, 32'h0, 32'h55, 32'h66, 32'h1c000000);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid",   u_if.es_to_ms_valid,   1'b0);
    chk("rst_allowin", u_if.es_allowin,       1'b1);
    chk("rst_en",      u_if.data_sram_en,     1'b0);
    chk("rst_we",      u_if.data_sram_we,     4'h0);
    chk("rst_haz_vld", u_if.es_hazard_bus[6], 1'b0);
    resetn = 1'b1;
    u_if.ds_to_es_valid = 1'b0;
    u_if.ms_allowin = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_valid", u_if.es_to_ms_valid, 1'b0);

    // Back-to-back ALU vectors, one per cycle.
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].op, 1'b0, tbl[i].s1pc, tbl[i].s2imm, 1'b1, 1'b0, tbl[i].dest,
            tbl[i].imm, tbl[i].rj, tbl[i].rkd, tbl[i].pc);
      exp_q.push_back({1'b0, 1'b1, tbl[i].dest, tbl[i].exp, tbl[i].pc});
      @(posedge clk);
      #1;
      chk($sformatf("alu_fwd%0d", i), u_if.es_forward,     tbl[i].exp);
      chk($sformatf("alu_vld%0d", i), u_if.es_to_ms_valid, 1'b1);
      chk($sformatf("alu_en%0d", i),  u_if.data_sram_en,   1'b0);
    end
    u_if.ds_to_es_valid = 1'b0;

    // Store: exactly one write cycle.
    drive(OP_ADD, 1'b0, 0, 1, 1'b0, 1'b1, 5'd0, 32'h8, 32'h1000, 32'hdeadbeef, 32'h1c000200);
    exp_q.push_back({1'b0, 1'b0, 5'd0, 32'h1008, 32'h1c000200});
    @(posedge clk);
    #1;
    u_if.ds_to_es_valid = 1'b0;
    chk("st_en",    u_if.data_sram_en,    1'b1);
    chk("st_we",    u_if.data_sram_we,    4'hf);
    chk("st_addr",  u_if.data_sram_addr,  32'h1008);
    chk("st_wdata", u_if.data_sram_wdata, 32'hdeadbeef);
    @(posedge clk);
    #1;
    chk("st_en_once", u_if.data_sram_en, 1'b0);
    chk("st_we_once", u_if.data_sram_we, 4'h0);

    // Load held by memory-stage stall, with a second instruction waiting in decode.
    u_if.ms_allowin = 1'b0;
    drive(OP_ADD, 1'b1, 0, 1, 1'b1, 1'b0, 5'd5, 32'h10, 32'h2000, 32'h0, 32'h1c000300);
    exp_q.push_back({1'b1, 1'b1, 5'd5, 32'h2010, 32'h1c000300});
    @(posedge clk);
    #1;
    drive(OP_OR, 1'b0, 0, 0, 1'b1, 1'b0, 5'd6, 32'h0, 32'h00f0, 32'h0f00, 32'h1c000304);
    exp_q.push_back({1'b0, 1'b1, 5'd6, 32'h0ff0, 32'h1c000304});
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("ld_stall_en%0d", k),  u_if.data_sram_en,  1'b0);
      chk($sformatf("ld_stall_ain%0d", k), u_if.es_allowin,    1'b0);
      chk($sformatf("ld_stall_haz%0d", k), u_if.es_hazard_bus, {1'b1, 1'b1, 1'b1, 5'd5});
      chk($sformatf("ld_stall_bus%0d", k), {57'b0, u_if.es_to_ms_bus},
          {57'b0, 1'b1, 1'b1, 5'd5, 32'h2010, 32'h1c000300});
      @(posedge clk);
      #1;
    end
    u_if.ms_allowin = 1'b1;
    #1;
    chk("ld_rel_en",   u_if.data_sram_en,   1'b1);
    chk("ld_rel_we",   u_if.data_sram_we,   4'h0);
    chk("ld_rel_addr", u_if.data_sram_addr, 32'h2010);
    chk("ld_rel_ain",  u_if.es_allowin,     1'b1);
    @(posedge clk);
    #1;
    u_if.ds_to_es_valid = 1'b0;
    chk("b2b_fwd", u_if.es_forward,   32'h0ff0);
    chk("b2b_en",  u_if.data_sram_en, 1'b0);
    @(posedge clk);
    #1;

    // Reset while a valid instruction is stalled: it is discarded.
    u_if.ms_allowin = 1'b0;
    drive(OP_ADD, 1'b1, 0, 1, 1'b1, 1'b0, 5'd7, 32'h4, 32'h3000, 32'h0, 32'h1c000400);
    @(posedge clk);
    #1;
    chk("pre_rst_valid", u_if.es_to_ms_valid, 1'b1);
    resetn = 1'b0;
    drive(OP_ADD, 1'b0, 0, 0, 1'b1, 1'b0, 5'd8, 32'h0, 32'h1, 32'h1, 32'h1c000404);
    @(posedge clk);
    #1;
    chk("mrst_valid", u_if.es_to_ms_valid,   1'b0);
    chk("mrst_en",    u_if.data_sram_en,     1'b0);
    chk("mrst_haz",   u_if.es_hazard_bus[6], 1'b0);
    chk("mrst_ain",   u_if.es_allowin,       1'b1);
    resetn = 1'b1;
    drive(OP_XOR, 1'b0, 0, 0, 1'b1, 1'b0, 5'd9, 32'h0, 32'haaaa5555, 32'hffffffff, 32'h1c000408);
    exp_q.push_back({1'b0, 1'b1, 5'd9, 32'h5555aaaa, 32'h1c000408});
    @(posedge clk);
    #1;
    u_if.ms_allowin = 1'b1;
    u_if.ds_to_es_valid = 1'b0;
    chk("post_rst_valid", u_if.es_to_ms_valid, 1'b1);
    chk("post_rst_fwd",   u_if.es_forward,     32'h5555aaaa);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", exp_q.size(), 0);
    chk("end_idle",   u_if.es_to_ms_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
